// File: rtl/dac_sched_pkg.sv
// rtl/dac_sched_pkg.sv - shared constants, FSM state type and frame packing for the DAC update scheduler
// Purpose: DAC command/address codes, scheduler state encoding and the 24-bit frame builder.
// Ports: none (package).
package dac_sched_pkg;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
    localparam logic [3:0] CMD_WRITE_INPUT  = 4'h0;
    localparam logic [3:0] CMD_UPDATE_ALL   = 4'h2;
    localparam logic [3:0] ADDR_ALL         = 4'hF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } sched_state_t;

    function automatic logic [23:0] pack_frame(input logic [3:0]  cmd,
                                               input logic [3:0]  addr,
                                               input logic [15:0] data);
        return {cmd, addr, data};
    endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// rtl/dac_rr_arbiter.sv - combinational round-robin arbiter over the pending-channel vector
// Purpose: picks the first pending channel at or after the pointer, wrapping modulo NUM_CH.
// Ports:
//   i_Pending  in  NUM_CH  request vector
//   i_Pointer  in  CW      highest-priority channel index
//   o_Grant    out NUM_CH  one-hot grant (zero when nothing pending)
//   o_Valid    out 1       any request granted
module dac_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_Pending,
    input  logic [CW-1:0]     i_Pointer,
    output logic [NUM_CH-1:0] o_Grant,
    output logic              o_Valid
);

    logic [CW-1:0] w_idx;

    always_comb begin
        o_Grant = '0;
        o_Valid = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = CW'((int'(i_Pointer) + i) % NUM_CH);
            if (!o_Valid && i_Pending[w_idx]) begin
                o_Grant[w_idx] = 1'b1;
                o_Valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_update_scheduler.sv
// rtl/dac_update_scheduler.sv - shares one 24-bit SPI DAC transmitter between NUM_CH channels
// Purpose: latches channel writes, marks them pending and round-robin serialises
//   {CMD, ADDR, DATA} frames into the transmitter with a per-wait-state timeout.
// Optional feature: DAC_SCHED_SYNC_LOAD_EN - channel frames load input registers only
//   and one update-all frame {2, F, 0000} follows once every pending channel is sent.
// Ports:
//   i_Clock      in  1       system clock
//   i_Reset      in  1       asynchronous active-high reset
//   i_Wr_En      in  1       write strobe (no back-pressure)
//   i_Wr_Chan    in  CW      channel index; values >= NUM_CH ignored
//   i_Wr_Data    in  16      channel value
//   o_DAC_Data   out 24      frame to transmitter
//   o_DAC_Send   out 1       one-cycle start pulse
//   i_DAC_Ready  in  1       transmitter idle
//   o_Pending    out NUM_CH  per-channel unsent flags
//   o_Busy       out 1       FSM not in IDLE
//   o_Timeout    out 1       sticky wait-state timeout flag
module dac_update_scheduler
    import dac_sched_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  TIMEOUT = 1023,
    localparam int CW      = $clog2(NUM_CH)
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_En,
    input  logic [CW-1:0]     i_Wr_Chan,
    input  logic [15:0]       i_Wr_Data,
    output logic [23:0]       o_DAC_Data,
    output logic              o_DAC_Send,
    input  logic              i_DAC_Ready,
    output logic [NUM_CH-1:0] o_Pending,
    output logic              o_Busy,
    output logic              o_Timeout
);

`ifdef DAC_SCHED_SYNC_LOAD_EN
    localparam logic [3:0] CH_CMD = CMD_WRITE_INPUT;
`else
    localparam logic [3:0] CH_CMD = CMD_WRITE_UPDATE;
`endif

    sched_state_t      r_state;
    sched_state_t      w_state_next;
    logic [15:0]       r_value [NUM_CH];
    logic [NUM_CH-1:0] r_pending;
    logic [CW-1:0]     r_ptr;
    logic [CW-1:0]     r_gnt_ch;
    logic [23:0]       r_data;
    logic [9:0]        r_wait_cnt;
    logic              r_timeout;

    logic [NUM_CH-1:0] w_arb_grant;
    logic              w_arb_valid;
    logic [CW-1:0]     w_grant_ch;
    logic              w_wr_hit;
    logic [NUM_CH-1:0] w_wr_onehot;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_set;
    logic              w_do_grant_ch;
    logic              w_do_grant;
    logic              w_waiting;
    logic              w_expired;
    logic              w_abort;

`ifdef DAC_SCHED_SYNC_LOAD_EN
    logic r_sync_needed;
    logic r_gnt_all;
    logic w_do_grant_all;
`endif

    dac_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_arb (
        .i_Pending (r_pending),
        .i_Pointer (r_ptr),
        .o_Grant   (w_arb_grant),
        .o_Valid   (w_arb_valid)
    );

    always_comb begin
        w_grant_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_arb_grant[i]) begin
                w_grant_ch = CW'(i);
            end
        end
    end

    assign w_wr_hit    = i_Wr_En && (int'(i_Wr_Chan) < NUM_CH);
    assign w_wr_onehot = w_wr_hit ? (NUM_CH'(1) << i_Wr_Chan) : '0;

    assign w_do_grant_ch = (r_state == IDLE) && i_DAC_Ready && w_arb_valid;
`ifdef DAC_SCHED_SYNC_LOAD_EN
    // Channel requests, including writes that land while the update-all frame is
    // still waiting, always win over the update-all frame.
    assign w_do_grant_all = (r_state == IDLE) && i_DAC_Ready && !w_arb_valid && r_sync_needed;
    assign w_do_grant     = w_do_grant_ch || w_do_grant_all;
`else
    assign w_do_grant     = w_do_grant_ch;
`endif

    assign w_waiting = (r_state == WAIT_LOW  &&  i_DAC_Ready) ||
                       (r_state == WAIT_HIGH && !i_DAC_Ready);
    assign w_expired = (r_wait_cnt == 10'(TIMEOUT));
    assign w_abort   = w_waiting && w_expired;

    // A write on the grant edge must survive the clear, so set wins over clear.
    assign w_clr = w_do_grant_ch ? w_arb_grant : '0;
`ifdef DAC_SCHED_SYNC_LOAD_EN
    assign w_set = w_wr_onehot | ((w_abort && !r_gnt_all) ? (NUM_CH'(1) << r_gnt_ch) : '0);
`else
    assign w_set = w_wr_onehot | (w_abort ? (NUM_CH'(1) << r_gnt_ch) : '0);
`endif

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_do_grant) w_state_next = SEND;
            SEND:      w_state_next = WAIT_LOW;
            WAIT_LOW:  if (!i_DAC_Ready) w_state_next = WAIT_HIGH;
                       else if (w_expired) w_state_next = IDLE;
            WAIT_HIGH: if (i_DAC_Ready) w_state_next = IDLE;
                       else if (w_expired) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_DAC_Send = (r_state == SEND);
        o_Busy     = (r_state != IDLE);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_value[i] <= '0;
            end
            r_pending  <= '0;
            r_ptr      <= '0;
            r_gnt_ch   <= '0;
            r_data     <= '0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_wr_hit) begin
                r_value[i_Wr_Chan] <= i_Wr_Data;
            end
            r_pending <= (r_pending & ~w_clr) | w_set;

            if (w_do_grant_ch) begin
                r_data   <= pack_frame(CH_CMD, 4'(w_grant_ch), r_value[w_grant_ch]);
                r_gnt_ch <= w_grant_ch;
                r_ptr    <= CW'((int'(w_grant_ch) + 1) % NUM_CH);
            end
`ifdef DAC_SCHED_SYNC_LOAD_EN
            else if (w_do_grant_all) begin
                r_data <= pack_frame(CMD_UPDATE_ALL, ADDR_ALL, 16'h0000);
            end
`endif

            // Counter restarts on every state change so each wait state gets a full budget.
            if (w_state_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_waiting && !w_expired) begin
                r_wait_cnt <= r_wait_cnt + 10'd1;
            end

            if (w_abort) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef DAC_SCHED_SYNC_LOAD_EN
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_sync_needed <= 1'b0;
            r_gnt_all     <= 1'b0;
        end else begin
            if (w_do_grant) begin
                r_gnt_all <= w_do_grant_all;
            end
            if (w_do_grant_ch) begin
                r_sync_needed <= 1'b1;
            end else if (w_do_grant_all) begin
                r_sync_needed <= 1'b0;
            end else if (w_abort && r_gnt_all) begin
                r_sync_needed <= 1'b1;
            end
        end
    end
`endif

    assign o_DAC_Data = r_data;
    assign o_Pending  = r_pending;
    assign o_Timeout  = r_timeout;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// tb/tb_dac_update_scheduler.sv - directed self-checking bench for dac_update_scheduler
module tb_dac_update_scheduler;

    localparam int NUM_CH    = 4;
    localparam int TIMEOUT   = 1023;
    localparam int BUSY_CLKS = 26;
`ifdef DAC_SCHED_SYNC_LOAD_EN
    localparam logic [3:0] CMD_CH = 4'h0;
    localparam int         UPD_PER_BATCH = 1;
`else
    localparam logic [3:0] CMD_CH = 4'h3;
    localparam int         UPD_PER_BATCH = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_chan = '0;
    logic [15:0] wr_data = '0;
    logic [23:0] dac_data;
    logic        send;
    logic        ready;
    logic [3:0]  pending;
    logic        busy;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    // Transmitter model: goes busy for BUSY_CLKS after accepting a Send pulse.
    int          busy_cnt = 0;
    logic        hold_busy = 1'b0;
    logic        ignore_send = 1'b0;
    logic        send_d = 1'b0;
    logic [23:0] frames[$];
    int          upd_frames = 0;
    int          send_total = 0;
    int          send_bad = 0;

    assign ready = (busy_cnt == 0) && !hold_busy;

    always #10 clk = ~clk;

    dac_update_scheduler #(
        .NUM_CH  (NUM_CH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Wr_En     (wr_en),
        .i_Wr_Chan   (wr_chan),
        .i_Wr_Data   (wr_data),
        .o_DAC_Data  (dac_data),
        .o_DAC_Send  (send),
        .i_DAC_Ready (ready),
        .o_Pending   (pending),
        .o_Busy      (busy),
        .o_Timeout   (tmo)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
            send_d   <= 1'b0;
        end else begin
            send_d <= send;
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            else if (send && !ignore_send) busy_cnt <= BUSY_CLKS;
            if (send) begin
                send_total <= send_total + 1;
                if (dac_data == 24'h2F0000) upd_frames <= upd_frames + 1;
                else frames.push_back(dac_data);
                if (!ready || send_d) send_bad <= send_bad + 1;
            end
        end
    end

    task automatic write_ch(input logic [1:0] ch, input logic [15:0] d);
        wr_chan = ch;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_send(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            if (send) break;
            @(posedge clk); #1;
        end
        checks++;
        if (i == 300) begin
            errors++;
            $display("FAIL %s: no send pulse within 300 cycles, required one", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int i;
        int quiet;
        quiet = 0;
        for (i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            if (!busy && pending == 4'h0 && ready) quiet++;
            else quiet = 0;
            if (quiet >= 2) break;
        end
        checks++;
        if (quiet < 2) begin
            errors++;
            $display("FAIL %s: scheduler not idle after 800 cycles (busy=%0b pending=%h), required idle", name, busy, pending);
        end
    endtask

    task automatic wait_frames(input int n, input string name);
        int i;
        for (i = 0; i < 800; i++) begin
            if (frames.size() >= n) break;
            @(posedge clk); #1;
        end
        checks++;
        if (frames.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d frames, required %0d", name, frames.size(), n);
        end
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (dac_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h required 000000", dac_data); end
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b required 0", send); end
        checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending: got %h required 0", pending); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b required 0", tmo); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_single_write();
        logic [23:0] exp;
        exp = {CMD_CH, 4'h2, 16'hABCD};
        write_ch(2'd2, 16'hABCD);
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending_set: got %h required 4", pending); end
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL single_send_early: got %b required 0", send); end
        step(1);
        checks++; if (send !== 1'b1) begin errors++; $display("FAIL single_latency: send=%b required 1", send); end
        checks++; if (dac_data !== exp) begin errors++; $display("FAIL single_frame: got %h required %h", dac_data, exp); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_pending_clr: got %h required 0", pending); end
        step(1);
        checks++; if (send !== 1'b0) begin errors++; $display("FAIL single_pulse_width: send=%b required 0", send); end
        step(10);
        checks++; if (dac_data !== exp) begin errors++; $display("FAIL single_data_stable: got %h required %h", dac_data, exp); end
        wait_idle("single_idle");
        checks++; if (send_total !== 1 + UPD_PER_BATCH) begin errors++; $display("FAIL single_send_count: got %0d required %0d", send_total, 1 + UPD_PER_BATCH); end
    endtask

    task automatic test_round_robin();
        int base;
        logic [23:0] exp [4];
        write_ch(2'd0, 16'h0F00);
        wait_idle("rr_prime_idle");
        hold_busy = 1'b1;
        for (int k = 0; k < 4; k++) write_ch(2'(k), 16'hC0C0 + 16'(k));
        checks++; if (pending !== 4'hF || busy !== 1'b0) begin errors++; $display("FAIL rr_hold: pending=%h busy=%b required F/0", pending, busy); end
        base = frames.size();
        hold_busy = 1'b0;
        exp[0] = {CMD_CH, 4'h1, 16'hC0C1};
        exp[1] = {CMD_CH, 4'h2, 16'hC0C2};
        exp[2] = {CMD_CH, 4'h3, 16'hC0C3};
        exp[3] = {CMD_CH, 4'h0, 16'hC0C0};
        wait_frames(base + 4, "rr_frames");
        for (int k = 0; k < 4; k++) begin
            if (frames.size() > base + k) begin
                checks++;
                if (frames[base + k] !== exp[k]) begin errors++; $display("FAIL rr_order_%0d: got %h required %h", k, frames[base + k], exp[k]); end
            end
        end
        wait_idle("rr_idle");
    endtask

    task automatic test_overwrite();
        int base;
        logic [23:0] e;
        base = frames.size();
        write_ch(2'd1, 16'h1111);
        step(5);
        write_ch(2'd1, 16'h2222);
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovw_pending: got %h required 2", pending); end
        wait_frames(base + 2, "ovw_frames");
        if (frames.size() >= base + 2) begin
            e = {CMD_CH, 4'h1, 16'h1111};
            checks++; if (frames[base] !== e) begin errors++; $display("FAIL ovw_first: got %h required %h", frames[base], e); end
            e = {CMD_CH, 4'h1, 16'h2222};
            checks++; if (frames[base + 1] !== e) begin errors++; $display("FAIL ovw_second: got %h required %h", frames[base + 1], e); end
        end
        wait_idle("ovw_idle");
        hold_busy = 1'b1;
        write_ch(2'd3, 16'h3333);
        hold_busy = 1'b0;
        wr_chan = 2'd3; wr_data = 16'h4444; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        e = {CMD_CH, 4'h3, 16'h3333};
        checks++; if (send !== 1'b1 || dac_data !== e) begin errors++; $display("FAIL gedge_frame: send=%b data=%h required 1/%h", send, dac_data, e); end
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL gedge_pending: got %h required 8", pending); end
        wait_frames(base + 4, "gedge_frames");
        if (frames.size() >= base + 4) begin
            e = {CMD_CH, 4'h3, 16'h4444};
            checks++; if (frames[base + 3] !== e) begin errors++; $display("FAIL gedge_resend: got %h required %h", frames[base + 3], e); end
        end
        wait_idle("gedge_idle");
    endtask

    task automatic test_timeout();
        int n;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_pre: got %b required 0", tmo); end
        ignore_send = 1'b1;
        write_ch(2'd2, 16'h5A5A);
        step(1);
        checks++; if (send !== 1'b1) begin errors++; $display("FAIL tmo_send: got %b required 1", send); end
        n = 0;
        while (n < 1200 && !tmo) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!tmo || n < TIMEOUT || n > TIMEOUT + 2) begin
            errors++;
            $display("FAIL tmo_delay: timeout=%b after %0d cycles, required 1 after %0d..%0d", tmo, n, TIMEOUT, TIMEOUT + 2);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle: busy=%b required 0", busy); end
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL tmo_repend: got %h required 4", pending); end
        ignore_send = 1'b0;
        wait_idle("tmo_recover");
        checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", tmo); end
    endtask

    task automatic test_reset_mid();
        int base;
        write_ch(2'd0, 16'h0BAD);
        wait_send("rst_send");
        step(5);
        write_ch(2'd3, 16'h7777);
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL rst_in_wait: busy=%b ready=%b required 1/0", busy, ready); end
        #3 rst = 1'b1;
        #1;
        checks++; if (dac_data !== 24'h0 || send !== 1'b0) begin errors++; $display("FAIL rst_async_out: data=%h send=%b required 000000/0", dac_data, send); end
        checks++; if (pending !== 4'h0 || busy !== 1'b0 || tmo !== 1'b0) begin errors++; $display("FAIL rst_async_flags: pending=%h busy=%b tmo=%b required 0/0/0", pending, busy, tmo); end
        step(2);
        rst = 1'b0;
        base = send_total;
        step(50);
        checks++; if (send_total !== base) begin errors++; $display("FAIL rst_no_send: got %0d sends required %0d", send_total, base); end
    endtask

    task automatic test_sync_load();
        int base;
        int ubase;
        logic [23:0] e;
        base  = frames.size();
        ubase = upd_frames;
        write_ch(2'd0, 16'h1234);
        step(3);
        write_ch(2'd3, 16'h5678);
        wait_idle("sync_idle");
        wait_frames(base + 2, "sync_frames");
        if (frames.size() >= base + 2) begin
            e = {CMD_CH, 4'h0, 16'h1234};
            checks++; if (frames[base] !== e) begin errors++; $display("FAIL sync_ch0: got %h required %h", frames[base], e); end
            e = {CMD_CH, 4'h3, 16'h5678};
            checks++; if (frames[base + 1] !== e) begin errors++; $display("FAIL sync_ch3: got %h required %h", frames[base + 1], e); end
        end
        checks++; if (upd_frames - ubase !== UPD_PER_BATCH) begin errors++; $display("FAIL sync_update_all: got %0d required %0d", upd_frames - ubase, UPD_PER_BATCH); end
        e = (UPD_PER_BATCH != 0) ? 24'h2F0000 : {CMD_CH, 4'h3, 16'h5678};
        checks++; if (dac_data !== e) begin errors++; $display("FAIL sync_last_frame: got %h required %h", dac_data, e); end
    endtask

    task automatic test_back_to_back();
        checks++; if (send_bad !== 0) begin errors++; $display("FAIL send_protocol: got %0d bad pulses required 0", send_bad); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_overwrite();
        test_timeout();
        test_reset_mid();
        test_sync_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
